// File: rtl/vga_timing_gen.sv
// Raster timing generator for a 1280x800 display: pixel/line counters, syncs,
// active-area flag, frame/vblank strobes and delay-matched pin outputs.
module vga_timing_gen #(
    parameter int H_ACTIVE = 1280,
    parameter int H_FP     = 72,
    parameter int H_SYNC   = 128,
    parameter int H_BP     = 200,
    parameter int V_ACTIVE = 800,
    parameter int V_FP     = 3,
    parameter int V_SYNC   = 6,
    parameter int V_BP     = 22,
    parameter bit HS_POL   = 1'b0,
    parameter bit VS_POL   = 1'b1,
    parameter int OUT_DLY  = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        pix_en,
    output logic [10:0] curr_x,
    output logic [9:0]  curr_y,
    output logic        active_area,
    output logic        hsync,
    output logic        vsync,
    output logic        frame_start,
    output logic        vblank_start,
    output logic        hsync_o,
    output logic        vsync_o,
    output logic        de_o
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    if (H_TOTAL > 2048) begin : g_bad_h_total
        $error("vga_timing_gen: H_TOTAL exceeds 2048");
    end
    if (V_TOTAL > 1024) begin : g_bad_v_total
        $error("vga_timing_gen: V_TOTAL exceeds 1024");
    end
    if (OUT_DLY > 4 || OUT_DLY < 0) begin : g_bad_out_dly
        $error("vga_timing_gen: OUT_DLY must be 0..4");
    end

    // Comparison bounds carry one spare bit so a window ending at the raster edge still fits.
    localparam logic [10:0] X_LAST   = 11'(H_TOTAL - 1);
    localparam logic [9:0]  Y_LAST   = 10'(V_TOTAL - 1);
    localparam logic [11:0] X_ACT    = 12'(H_ACTIVE);
    localparam logic [11:0] X_HS_BEG = 12'(H_ACTIVE + H_FP);
    localparam logic [11:0] X_HS_END = 12'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [10:0] Y_ACT    = 11'(V_ACTIVE);
    localparam logic [10:0] Y_VS_BEG = 11'(V_ACTIVE + V_FP);
    localparam logic [10:0] Y_VS_END = 11'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [2:0]  PIN_IDLE = {~HS_POL, ~VS_POL, 1'b0};

    logic [10:0] x_r;
    logic [9:0]  y_r;
    logic        active_r;
    logic        hsync_r;
    logic        vsync_r;
    logic        frame_start_r;
    logic        vblank_start_r;

    logic [10:0] x_nxt_s;
    logic [9:0]  y_nxt_s;
    logic [11:0] x_ext_s;
    logic [10:0] y_ext_s;
    logic        active_nxt_s;
    logic        hsync_nxt_s;
    logic        vsync_nxt_s;
    logic        frame_start_nxt_s;
    logic        vblank_start_nxt_s;

    // Next counter position and the outputs decoded from it, so registered flags match the counters.
    always_comb begin
        x_nxt_s = x_r;
        y_nxt_s = y_r;
        if (pix_en) begin
            if (x_r == X_LAST) begin
                x_nxt_s = 11'd0;
                if (y_r == Y_LAST) begin
                    y_nxt_s = 10'd0;
                end else begin
                    y_nxt_s = y_r + 10'd1;
                end
            end else begin
                x_nxt_s = x_r + 11'd1;
            end
        end else begin
            x_nxt_s = x_r;
            y_nxt_s = y_r;
        end
        x_ext_s            = {1'b0, x_nxt_s};
        y_ext_s            = {1'b0, y_nxt_s};
        active_nxt_s       = (x_ext_s < X_ACT) && (y_ext_s < Y_ACT);
        hsync_nxt_s        = ((x_ext_s >= X_HS_BEG) && (x_ext_s < X_HS_END)) ? HS_POL : ~HS_POL;
        vsync_nxt_s        = ((y_ext_s >= Y_VS_BEG) && (y_ext_s < Y_VS_END)) ? VS_POL : ~VS_POL;
        frame_start_nxt_s  = pix_en && (x_nxt_s == 11'd0) && (y_nxt_s == 10'd0);
        vblank_start_nxt_s = pix_en && (x_nxt_s == 11'd0) && (y_ext_s == Y_ACT);
    end

    // Counter and counter-aligned output registers; reset parks on the last pixel of a frame.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x_r            <= X_LAST;
            y_r            <= Y_LAST;
            active_r       <= 1'b0;
            hsync_r        <= ~HS_POL;
            vsync_r        <= ~VS_POL;
            frame_start_r  <= 1'b0;
            vblank_start_r <= 1'b0;
        end else begin
            x_r            <= x_nxt_s;
            y_r            <= y_nxt_s;
            active_r       <= active_nxt_s;
            hsync_r        <= hsync_nxt_s;
            vsync_r        <= vsync_nxt_s;
            frame_start_r  <= frame_start_nxt_s;
            vblank_start_r <= vblank_start_nxt_s;
        end
    end

    assign curr_x       = x_r;
    assign curr_y       = y_r;
    assign active_area  = active_r;
    assign hsync        = hsync_r;
    assign vsync        = vsync_r;
    assign frame_start  = frame_start_r;
    assign vblank_start = vblank_start_r;

    if (OUT_DLY == 0) begin : g_no_dly
        assign hsync_o = hsync_r;
        assign vsync_o = vsync_r;
        assign de_o    = active_r;
    end else begin : g_dly
        logic [2:0] dly_r [OUT_DLY];

        // Pin delay line runs every clk, independent of pix_en, to match downstream pad latency.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                for (int i = 0; i < OUT_DLY; i++) begin
                    dly_r[i] <= PIN_IDLE;
                end
            end else begin
                dly_r[0] <= {hsync_r, vsync_r, active_r};
                for (int i = 1; i < OUT_DLY; i++) begin
                    dly_r[i] <= dly_r[i-1];
                end
            end
        end

        assign {hsync_o, vsync_o, de_o} = dly_r[OUT_DLY-1];
    end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Scoreboard bench: a default 1280x800 instance plus a tiny raster (24x12, OUT_DLY=3)
// so whole frames and the deep delay line fit in a short run.
module tb_vga_timing_gen;

    logic clk    = 1'b0;
    logic rst_n  = 1'b1;
    logic pix_en = 1'b0;

    logic [10:0] a_x, b_x;
    logic [9:0]  a_y, b_y;
    logic a_act, a_hs, a_vs, a_fs, a_vb, a_hs_o, a_vs_o, a_de_o;
    logic b_act, b_hs, b_vs, b_fs, b_vb, b_hs_o, b_vs_o, b_de_o;

    always #5 clk = ~clk;

    vga_timing_gen dut_a (
        .clk(clk), .rst_n(rst_n), .pix_en(pix_en),
        .curr_x(a_x), .curr_y(a_y), .active_area(a_act),
        .hsync(a_hs), .vsync(a_vs), .frame_start(a_fs), .vblank_start(a_vb),
        .hsync_o(a_hs_o), .vsync_o(a_vs_o), .de_o(a_de_o)
    );

    vga_timing_gen #(
        .H_ACTIVE(16), .H_FP(2), .H_SYNC(4), .H_BP(2),
        .V_ACTIVE(8), .V_FP(1), .V_SYNC(2), .V_BP(1),
        .HS_POL(1'b0), .VS_POL(1'b1), .OUT_DLY(3)
    ) dut_b (
        .clk(clk), .rst_n(rst_n), .pix_en(pix_en),
        .curr_x(b_x), .curr_y(b_y), .active_area(b_act),
        .hsync(b_hs), .vsync(b_vs), .frame_start(b_fs), .vblank_start(b_vb),
        .hsync_o(b_hs_o), .vsync_o(b_vs_o), .de_o(b_de_o)
    );

    typedef struct packed {
        logic [10:0] x;
        logic [9:0]  y;
        logic act, hs, vs, fs, vb, deo, hso, vso;
    } obs_t;

    localparam bit HSP = 1'b0;
    localparam bit VSP = 1'b1;
    int HA[2]  = '{1280, 16};
    int HF[2]  = '{72, 2};
    int HSY[2] = '{128, 4};
    int HT[2]  = '{1680, 24};
    int VA[2]  = '{800, 8};
    int VF[2]  = '{3, 1};
    int VSY[2] = '{6, 2};
    int VT[2]  = '{831, 12};
    int DLY[2] = '{1, 3};

    obs_t q_a[$];
    obs_t q_b[$];
    int   mx[2];
    int   my[2];
    logic mfs[2];
    logic mvb[2];
    logic [2:0] hist[2][4];

    int n_assert = 0;
    int n_fail   = 0;
    int cyc      = 0;

    task automatic check(input string name, input int got, input int want);
        n_assert++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %0d, required %0d", name, got, want);
        end
    endtask

    // {active, hsync, vsync} for a raster position
    function automatic logic [2:0] outs(input int d, input int x, input int y);
        logic act, hs, vs;
        act = (x < HA[d]) && (y < VA[d]);
        hs  = (x >= HA[d] + HF[d] && x < HA[d] + HF[d] + HSY[d]) ? HSP : ~HSP;
        vs  = (y >= VA[d] + VF[d] && y < VA[d] + VF[d] + VSY[d]) ? VSP : ~VSP;
        return {act, hs, vs};
    endfunction

    function automatic obs_t mk(input int d);
        logic [2:0] o;
        logic [2:0] p;
        o = outs(d, mx[d], my[d]);
        p = hist[d][DLY[d]-1];
        return {11'(mx[d]), 10'(my[d]), o, mfs[d], mvb[d], p};
    endfunction

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            mx[d]  = HT[d] - 1;
            my[d]  = VT[d] - 1;
            mfs[d] = 1'b0;
            mvb[d] = 1'b0;
            for (int k = 0; k < 4; k++) hist[d][k] = {1'b0, ~HSP, ~VSP};
        end
    endtask

    task automatic model_edge(input bit pe);
        logic [2:0] old;
        if (!rst_n) begin
            model_reset();
        end else begin
            for (int d = 0; d < 2; d++) begin
                old = outs(d, mx[d], my[d]);
                for (int k = 3; k > 0; k--) hist[d][k] = hist[d][k-1];
                hist[d][0] = old;
                mfs[d] = 1'b0;
                mvb[d] = 1'b0;
                if (pe) begin
                    if (mx[d] == HT[d] - 1) begin
                        mx[d] = 0;
                        my[d] = (my[d] == VT[d] - 1) ? 0 : my[d] + 1;
                    end else begin
                        mx[d] = mx[d] + 1;
                    end
                    mfs[d] = (mx[d] == 0) && (my[d] == 0);
                    mvb[d] = (mx[d] == 0) && (my[d] == VA[d]);
                end
            end
        end
    endtask

    // Drive one clock of stimulus and queue the response expected after that edge
    task automatic step(input bit pe);
        pix_en = pe;
        @(posedge clk);
        #1;
        cyc++;
        model_edge(pe);
        q_a.push_back(mk(0));
        q_b.push_back(mk(1));
    endtask

    always @(negedge clk) begin : monitor
        obs_t got;
        obs_t want;
        if (q_a.size() > 0) begin
            want = q_a.pop_front();
            got  = {a_x, a_y, a_act, a_hs, a_vs, a_fs, a_vb, a_de_o, a_hs_o, a_vs_o};
            n_assert++;
            if (got !== want) begin
                n_fail++;
                $display("FAIL sb_a cyc %0d: got x=%0d y=%0d flags=%b, required x=%0d y=%0d flags=%b",
                         cyc, got.x, got.y, got[7:0], want.x, want.y, want[7:0]);
            end
        end
        if (q_b.size() > 0) begin
            want = q_b.pop_front();
            got  = {b_x, b_y, b_act, b_hs, b_vs, b_fs, b_vb, b_de_o, b_hs_o, b_vs_o};
            n_assert++;
            if (got !== want) begin
                n_fail++;
                $display("FAIL sb_b cyc %0d: got x=%0d y=%0d flags=%b, required x=%0d y=%0d flags=%b",
                         cyc, got.x, got.y, got[7:0], want.x, want.y, want[7:0]);
            end
        end
    end

    initial begin
        int  hs_cnt;
        int  hs_first;
        int  hs_last;
        int  last_fs;
        bit  found;
        hs_cnt   = 0;
        hs_first = -1;
        hs_last  = -1;
        last_fs  = -1;
        found    = 1'b0;

        model_reset();
        #2 rst_n = 1'b0;
        step(1'b0);
        step(1'b1);
        step(1'b1);
        check("rst_x", int'(a_x), 1679);
        check("rst_y", int'(a_y), 830);
        check("rst_act", int'(a_act), 0);
        check("rst_hsync", int'(a_hs), 1);
        check("rst_vsync", int'(a_vs), 0);
        check("rst_fs", int'(a_fs), 0);
        check("rst_de_o", int'(a_de_o), 0);
        check("rst_hsync_o", int'(a_hs_o), 1);
        check("rst_vsync_o", int'(a_vs_o), 0);

        rst_n = 1'b1;
        step(1'b1);
        check("first_x", int'(a_x), 0);
        check("first_y", int'(a_y), 0);
        check("first_act", int'(a_act), 1);
        check("first_fs", int'(a_fs), 1);
        check("first_b_fs", int'(b_fs), 1);
        step(1'b0);
        check("hold_x", int'(a_x), 0);
        check("fs_held", int'(a_fs), 0);
        check("a_de_o_dly1", int'(a_de_o), 1);
        check("b_de_o_e1", int'(b_de_o), 0);
        step(1'b0);
        check("hold2_x", int'(a_x), 0);
        check("b_de_o_e2", int'(b_de_o), 0);
        step(1'b1);
        check("en_x", int'(a_x), 1);
        check("b_de_o_dly3", int'(b_de_o), 1);

        // Run the big raster to the end of line 5 while the small raster cycles through frames
        for (int i = 0; i < 10078; i++) begin
            step(1'b1);
            if (a_y == 10'd5) begin
                if (a_x == 11'd1279) check("act_x1279", int'(a_act), 1);
                if (a_x == 11'd1280) check("act_x1280", int'(a_act), 0);
                if (a_hs == 1'b0) begin
                    hs_cnt++;
                    if (hs_first < 0) hs_first = int'(a_x);
                    hs_last = int'(a_x);
                end
            end
            if (b_fs) begin
                if (last_fs >= 0) check("fs_period", cyc - last_fs, 288);
                last_fs = cyc;
            end
            if (b_vb) begin
                check("vb_x", int'(b_x), 0);
                check("vb_y", int'(b_y), 8);
                if (last_fs >= 0) check("vb_after_fs", cyc - last_fs, 192);
            end
            if (b_x == 11'd20) check("hs_o_before_fall", int'(b_hs_o), 1);
            if (b_x == 11'd21) check("hs_o_fall_dly3", int'(b_hs_o), 0);
        end
        check("pre_wrap_x", int'(a_x), 1679);
        check("pre_wrap_y", int'(a_y), 5);
        step(1'b1);
        check("wrap_x", int'(a_x), 0);
        check("wrap_y", int'(a_y), 6);
        check("hs_low_count", hs_cnt, 128);
        check("hs_low_first", hs_first, 1352);
        check("hs_low_last", hs_last, 1479);

        for (int i = 0; i < 400 && !found; i++) begin
            if (b_x == 11'd10 && b_y == 10'd5) found = 1'b1;
            else step(1'b1);
        end
        check("find_mid_frame", int'(found), 1);

        // Asynchronous reset in the middle of a clock period
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_a_x", int'(a_x), 1679);
        check("mid_rst_a_y", int'(a_y), 830);
        check("mid_rst_a_hs", int'(a_hs), 1);
        check("mid_rst_a_de_o", int'(a_de_o), 0);
        check("mid_rst_b_x", int'(b_x), 23);
        check("mid_rst_b_y", int'(b_y), 11);
        check("mid_rst_b_act", int'(b_act), 0);
        check("mid_rst_b_de_o", int'(b_de_o), 0);
        check("mid_rst_b_hs_o", int'(b_hs_o), 1);
        check("mid_rst_b_vs_o", int'(b_vs_o), 0);
        model_reset();
        step(1'b1);
        step(1'b1);
        rst_n = 1'b1;
        step(1'b0);
        check("post_rst_hold_x", int'(a_x), 1679);
        step(1'b1);
        check("restart_a_x", int'(a_x), 0);
        check("restart_a_y", int'(a_y), 0);
        check("restart_a_fs", int'(a_fs), 1);
        check("restart_b_x", int'(b_x), 0);
        check("restart_b_fs", int'(b_fs), 1);
        for (int i = 0; i < 5; i++) step(1'b1);

        @(negedge clk);
        @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
